// File: rtl/tl_intersection_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tl_intersection_scheduler
//  Description : Round-robin green-time scheduler for a four-approach
//                intersection with a latched pedestrian walk phase.
//                Light codes per approach: 00 dark, 01 red, 10 yellow,
//                11 green. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module tl_intersection_scheduler #(
    parameter int MIN_GREEN    = 10,
    parameter int MAX_GREEN    = 30,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 2,
    parameter int WALK_TIME    = 8,
    parameter int CNT_W        = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       ped_req,
    output logic [7:0] light,
    output logic [1:0] grant,
    output logic       walk,
    output logic       ped_pending
);

    typedef enum logic [2:0] {
        S_DARK    = 3'd0,
        S_ALL_RED = 3'd1,
        S_GREEN   = 3'd2,
        S_YELLOW  = 3'd3,
        S_WALK    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_min_last    = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] c_max_last    = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] c_yellow_last = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] c_allred_last = CNT_W'(ALL_RED_TIME - 1);
    localparam logic [CNT_W-1:0] c_walk_last   = CNT_W'(WALK_TIME - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_ptr;
    logic [1:0]       r_grant;
    logic             r_ped_pending;
    logic             r_last_walk;   // previous non-clearance phase was WALK
    logic [7:0]       r_light;
    logic             r_walk;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_ptr_nxt;
    logic [1:0]       w_grant_nxt;
    logic             w_ped_nxt;
    logic             w_last_walk_nxt;
    logic [7:0]       w_light_nxt;
    logic             w_walk_nxt;
    logic [1:0]       w_pick;
    logic             w_ped_eff;
    logic             w_compete;
    logic [3:0]       w_others;
    logic [2:0]       w_nonred;

    assign light       = r_light;
    assign grant       = r_grant;
    assign walk        = r_walk;
    assign ped_pending = r_ped_pending;

    // A button press counts as pending in the same cycle it arrives.
    assign w_ped_eff = r_ped_pending | ped_req;
    assign w_others  = req & ~(4'b0001 << r_grant);
    assign w_compete = (|w_others) | w_ped_eff;

    // Round-robin search: ptr+1 has highest priority, ptr itself lowest.
    always_comb begin
        w_pick = r_ptr;
        for (int k = 4; k >= 1; k--) begin
            if (req[r_ptr + 2'(k)]) begin
                w_pick = r_ptr + 2'(k);
            end
        end
    end

    // Next-state, counter and scheduling decisions.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt + 1'b1;
        w_ptr_nxt       = r_ptr;
        w_grant_nxt     = r_grant;
        w_ped_nxt       = w_ped_eff;
        w_last_walk_nxt = r_last_walk;
        case (r_state)
            S_DARK: begin
                w_state_nxt = S_ALL_RED;
                w_cnt_nxt   = '0;
                w_ped_nxt   = 1'b0;
            end
            S_ALL_RED: begin
                if (r_cnt == c_allred_last) begin
                    w_cnt_nxt = '0;
                    if (w_ped_eff && !r_last_walk) begin
                        w_state_nxt     = S_WALK;
                        w_ped_nxt       = 1'b0;
                        w_last_walk_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = S_GREEN;
                        w_last_walk_nxt = 1'b0;
                        if (|req) begin
                            w_ptr_nxt   = w_pick;
                            w_grant_nxt = w_pick;
                        end else begin
                            w_grant_nxt = 2'd0;
                        end
                    end
                end
            end
            S_GREEN: begin
                if (w_compete && (r_cnt >= c_min_last)) begin
                    w_state_nxt = S_YELLOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_max_last) begin
                    w_cnt_nxt = '0;
                end
            end
            S_YELLOW: begin
                if (r_cnt == c_yellow_last) begin
                    w_state_nxt = S_ALL_RED;
                    w_cnt_nxt   = '0;
                end
            end
            S_WALK: begin
                if (r_cnt == c_walk_last) begin
                    w_state_nxt = S_ALL_RED;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_DARK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Light codes for the upcoming state, so outputs leave a register.
    always_comb begin
        w_light_nxt = 8'h00;
        w_walk_nxt  = (w_state_nxt == S_WALK);
        if (w_state_nxt != S_DARK) begin
            for (int i = 0; i < 4; i++) begin
                w_light_nxt[2*i +: 2] = 2'b01;
                if (2'(i) == w_grant_nxt) begin
                    if (w_state_nxt == S_GREEN) begin
                        w_light_nxt[2*i +: 2] = 2'b11;
                    end else if (w_state_nxt == S_YELLOW) begin
                        w_light_nxt[2*i +: 2] = 2'b10;
                    end
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_DARK;
            r_cnt         <= '0;
            r_ptr         <= 2'd3;
            r_grant       <= 2'd0;
            r_ped_pending <= 1'b0;
            r_last_walk   <= 1'b0;
            r_light       <= 8'h00;
            r_walk        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_ptr         <= w_ptr_nxt;
            r_grant       <= w_grant_nxt;
            r_ped_pending <= w_ped_nxt;
            r_last_walk   <= w_last_walk_nxt;
            r_light       <= w_light_nxt;
            r_walk        <= w_walk_nxt;
        end
    end

    // Number of approaches currently showing something other than red.
    always_comb begin
        w_nonred = 3'd0;
        for (int i = 0; i < 4; i++) begin
            w_nonred = w_nonred + 3'(r_light[2*i +: 2] != 2'b01);
        end
    end

    a_single_active : assert property (@(posedge clk) disable iff (rst)
        (r_state != S_DARK) |-> (w_nonred <= 3'd1));
    a_walk_all_red : assert property (@(posedge clk) disable iff (rst)
        r_walk |-> (r_light == 8'h55));
    a_green_exit : assert property (@(posedge clk) disable iff (rst)
        (r_state == S_GREEN) |=> ((r_state == S_YELLOW) ||
                                  ((r_state == S_GREEN) && $stable(r_grant))));
    a_yellow_exit : assert property (@(posedge clk) disable iff (rst)
        (r_state == S_YELLOW) |=> ((r_state == S_YELLOW) || (r_state == S_ALL_RED)));

endmodule
`default_nettype wire

// File: tb/tb_tl_intersection_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_tl_intersection_scheduler
//  Description : Self-checking bench: directed vector table, hand-written
//                pedestrian sequence, and randomized traffic against a
//                phase-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_intersection_scheduler;

    localparam int MIN_GREEN    = 10;
    localparam int MAX_GREEN    = 30;
    localparam int YELLOW_TIME  = 3;
    localparam int ALL_RED_TIME = 2;
    localparam int WALK_TIME    = 8;

    localparam int PH_DARK    = 0;
    localparam int PH_ALL_RED = 1;
    localparam int PH_GREEN   = 2;
    localparam int PH_YELLOW  = 3;
    localparam int PH_WALK    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'h0;
    logic       ped_req = 1'b0;
    logic [7:0] light;
    logic [1:0] grant;
    logic       walk;
    logic       ped_pending;

    int n_checks = 0;
    int n_errors = 0;

    tl_intersection_scheduler #(
        .MIN_GREEN   (MIN_GREEN),
        .MAX_GREEN   (MAX_GREEN),
        .YELLOW_TIME (YELLOW_TIME),
        .ALL_RED_TIME(ALL_RED_TIME),
        .WALK_TIME   (WALK_TIME),
        .CNT_W       (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ped_req    (ped_req),
        .light      (light),
        .grant      (grant),
        .walk       (walk),
        .ped_pending(ped_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic       r;
        logic [3:0] q;
        logic       p;
        logic [7:0] el;
        logic [1:0] eg;
        logic       ew;
        logic       ep;
        string      name;
    } vec_t;

    vec_t tbl[$];

    // Reference model: phase, time left in phase, age of a green.
    int m_phase = PH_DARK;
    int m_left  = 0;
    int m_age   = 0;
    int m_ptr   = 3;
    int m_grant = 0;
    bit m_ped   = 1'b0;
    bit m_last_walk = 1'b0;

    function automatic void model_step(logic r, logic [3:0] q, logic p);
        bit         ped_eff;
        bit         pend_new;
        bit         compete;
        int         pick;
        logic [3:0] mask;
        if (r) begin
            m_phase = PH_DARK; m_ptr = 3; m_grant = 0; m_ped = 1'b0;
            m_last_walk = 1'b0; m_left = 0; m_age = 0;
            return;
        end
        ped_eff  = m_ped | p;
        pend_new = (m_phase == PH_DARK) ? 1'b0 : ped_eff;
        case (m_phase)
            PH_DARK: begin
                m_phase = PH_ALL_RED; m_left = ALL_RED_TIME;
            end
            PH_ALL_RED: begin
                if (m_left > 1) m_left--;
                else if (ped_eff && !m_last_walk) begin
                    m_phase = PH_WALK; m_left = WALK_TIME;
                    pend_new = 1'b0; m_last_walk = 1'b1;
                end else begin
                    pick = -1;
                    for (int k = 1; k <= 4; k++) begin
                        if (pick < 0 && q[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
                    end
                    if (pick >= 0) begin
                        m_ptr = pick; m_grant = pick;
                    end else begin
                        m_grant = 0;
                    end
                    m_phase = PH_GREEN; m_age = 0; m_last_walk = 1'b0;
                end
            end
            PH_GREEN: begin
                mask    = 4'(1 << m_grant);
                compete = (|(q & ~mask)) || ped_eff;
                if (compete && m_age >= MIN_GREEN - 1) begin
                    m_phase = PH_YELLOW; m_left = YELLOW_TIME;
                end else begin
                    m_age = (m_age + 1) % MAX_GREEN;
                end
            end
            PH_YELLOW: begin
                if (m_left > 1) m_left--;
                else begin m_phase = PH_ALL_RED; m_left = ALL_RED_TIME; end
            end
            default: begin
                if (m_left > 1) m_left--;
                else begin m_phase = PH_ALL_RED; m_left = ALL_RED_TIME; end
            end
        endcase
        m_ped = pend_new;
    endfunction

    function automatic logic [7:0] model_light();
        logic [7:0] l;
        l = 8'h00;
        if (m_phase != PH_DARK) begin
            for (int i = 0; i < 4; i++) begin
                l[2*i +: 2] = 2'b01;
                if (i == m_grant && m_phase == PH_GREEN)  l[2*i +: 2] = 2'b11;
                if (i == m_grant && m_phase == PH_YELLOW) l[2*i +: 2] = 2'b10;
            end
        end
        return l;
    endfunction

    task automatic tick(input logic r, input logic [3:0] q, input logic p);
        @(negedge clk);
        rst = r; req = q; ped_req = p;
        @(posedge clk);
        model_step(r, q, p);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] el, input logic [1:0] eg,
                         input logic ew, input logic ep);
        n_checks++;
        if ({light, grant, walk, ped_pending} !== {el, eg, ew, ep}) begin
            n_errors++;
            $display("FAIL %s @%0t: got light=%h grant=%0d walk=%b ped_pending=%b, want light=%h grant=%0d walk=%b ped_pending=%b",
                     name, $time, light, grant, walk, ped_pending, el, eg, ew, ep);
        end
    endtask

    task automatic run_n(input int n, input logic r, input logic [3:0] q, input logic p,
                         input logic [7:0] el, input logic [1:0] eg, input logic ew,
                         input logic ep, input string name);
        for (int i = 0; i < n; i++) begin
            tick(r, q, p);
            check(name, el, eg, ew, ep);
        end
    endtask

    function automatic void add(int n, logic r, logic [3:0] q, logic p, logic [7:0] el,
                                logic [1:0] eg, logic ew, logic ep, string name);
        vec_t v;
        v.n = n; v.r = r; v.q = q; v.p = p; v.el = el; v.eg = eg; v.ew = ew; v.ep = ep;
        v.name = name;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [3:0] rq;
        logic       rp;
        logic       rr;

        // Reset release with no demand: rests on approach 0 with no yellow.
        add(1,  1, 4'h0, 0, 8'h00, 0, 0, 0, "t1_reset");
        add(2,  0, 4'h0, 0, 8'h55, 0, 0, 0, "t1_all_red");
        add(40, 0, 4'h0, 0, 8'h57, 0, 0, 0, "t1_rest_green");
        // req=0110 held: 1,2,1 alternation with exact phase lengths.
        add(1,  1, 4'h0, 0, 8'h00, 0, 0, 0, "t2_reset");
        add(2,  0, 4'h6, 0, 8'h55, 0, 0, 0, "t2_all_red");
        add(10, 0, 4'h6, 0, 8'h5D, 1, 0, 0, "t2_green1");
        add(3,  0, 4'h6, 0, 8'h59, 1, 0, 0, "t2_yellow1");
        add(2,  0, 4'h6, 0, 8'h55, 1, 0, 0, "t2_all_red1");
        add(10, 0, 4'h6, 0, 8'h75, 2, 0, 0, "t2_green2");
        add(3,  0, 4'h6, 0, 8'h65, 2, 0, 0, "t2_yellow2");
        add(2,  0, 4'h6, 0, 8'h55, 2, 0, 0, "t2_all_red2");
        add(10, 0, 4'h6, 0, 8'h5D, 1, 0, 0, "t2_green1_again");
        // req[3] arrives at green cycle 4 of approach 0.
        add(1,  1, 4'h0, 0, 8'h00, 0, 0, 0, "t3_reset");
        add(2,  0, 4'h0, 0, 8'h55, 0, 0, 0, "t3_all_red");
        add(5,  0, 4'h0, 0, 8'h57, 0, 0, 0, "t3_green0_early");
        add(5,  0, 4'h8, 0, 8'h57, 0, 0, 0, "t3_green0_to_min");
        add(3,  0, 4'h8, 0, 8'h56, 0, 0, 0, "t3_yellow0");
        add(2,  0, 4'h8, 0, 8'h55, 0, 0, 0, "t3_all_red");
        add(3,  0, 4'h8, 0, 8'hD5, 3, 0, 0, "t3_green3");
        // Reset in the middle of yellow, then the reset sequence again.
        add(7,  0, 4'h1, 0, 8'hD5, 3, 0, 0, "t6_green3");
        add(1,  0, 4'h1, 0, 8'h95, 3, 0, 0, "t6_yellow3");
        add(1,  1, 4'h1, 0, 8'h00, 0, 0, 0, "t6_reset_mid_yellow");
        add(2,  0, 4'h0, 0, 8'h55, 0, 0, 0, "t6_all_red");
        add(5,  0, 4'h0, 0, 8'h57, 0, 0, 0, "t6_rest_green");
        // Pedestrian pulse at green cycle 12 of approach 0.
        add(1,  1, 4'h0, 0, 8'h00, 0, 0, 0, "t4_reset");
        add(2,  0, 4'h0, 0, 8'h55, 0, 0, 0, "t4_all_red");
        add(13, 0, 4'h0, 0, 8'h57, 0, 0, 0, "t4_green0");
        add(1,  0, 4'h0, 1, 8'h56, 0, 0, 1, "t4_ped_ends_green");
        add(2,  0, 4'h0, 0, 8'h56, 0, 0, 1, "t4_yellow");
        add(2,  0, 4'h0, 0, 8'h55, 0, 0, 1, "t4_all_red");
        add(8,  0, 4'h0, 0, 8'h55, 0, 1, 0, "t4_walk");
        add(2,  0, 4'h0, 0, 8'h55, 0, 0, 0, "t4_all_red_post");
        add(3,  0, 4'h0, 0, 8'h57, 0, 0, 0, "t4_green_post");

        foreach (tbl[i]) begin
            run_n(tbl[i].n, tbl[i].r, tbl[i].q, tbl[i].p, tbl[i].el, tbl[i].eg,
                  tbl[i].ew, tbl[i].ep, tbl[i].name);
        end

        // Walk straight out of reset, press absorbed on WALK entry, a press
        // during WALK served only after one car phase.
        run_n(1,  1, 4'h0, 0, 8'h00, 0, 0, 0, "t5_reset");
        run_n(1,  0, 4'h0, 0, 8'h55, 0, 0, 0, "t5_all_red0");
        run_n(1,  0, 4'h0, 1, 8'h55, 0, 0, 1, "t5_ped_latch");
        run_n(1,  0, 4'h1, 1, 8'h55, 0, 1, 0, "t5_walk_entry_absorb");
        run_n(3,  0, 4'h1, 0, 8'h55, 0, 1, 0, "t5_walk");
        run_n(1,  0, 4'h1, 1, 8'h55, 0, 1, 1, "t5_ped_in_walk");
        run_n(3,  0, 4'h1, 0, 8'h55, 0, 1, 1, "t5_walk_tail");
        run_n(2,  0, 4'h1, 0, 8'h55, 0, 0, 1, "t5_all_red");
        run_n(10, 0, 4'h1, 0, 8'h57, 0, 0, 1, "t5_car_green");
        run_n(3,  0, 4'h1, 0, 8'h56, 0, 0, 1, "t5_yellow");
        run_n(2,  0, 4'h1, 0, 8'h55, 0, 0, 1, "t5_all_red2");
        run_n(1,  0, 4'h1, 0, 8'h55, 0, 1, 0, "t5_second_walk");

        // Randomized traffic against the reference model.
        tick(1'b1, 4'h0, 1'b0);
        rq = 4'h0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0) rq = 4'($urandom_range(0, 15));
            rp = ($urandom_range(0, 59) == 0);
            rr = ($urandom_range(0, 799) == 0);
            tick(rr, rq, rp);
            check("random", model_light(), 2'(m_grant), (m_phase == PH_WALK), m_ped);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
